// File: rtl/uut_run_pkg.sv
// Shared types and default parameters for the UUT run controller.
package uut_run_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam int unsigned DEF_BLOCK_W    = 64;
  localparam int unsigned DEF_KEY_W      = 80;
  localparam int unsigned DEF_MODE_W     = 8;
  localparam int unsigned DEF_OUT_W      = 64;
  localparam int unsigned DEF_RST_CYCLES = 4;
  localparam int unsigned DEF_TIMEOUT    = 65535;
  localparam int unsigned DEF_CNT_W      = 32;

endpackage

// File: rtl/uut_run_ctrl_if.sv
// Vector, UUT and result signals of the run controller, grouped as one bundle.
interface uut_run_if
  import uut_run_pkg::*;
#(
  parameter int unsigned BLOCK_W = DEF_BLOCK_W,
  parameter int unsigned KEY_W   = DEF_KEY_W,
  parameter int unsigned MODE_W  = DEF_MODE_W,
  parameter int unsigned OUT_W   = DEF_OUT_W,
  parameter int unsigned CNT_W   = DEF_CNT_W
) ();

  logic               abort_i;
  logic               vec_valid_i;
  logic               vec_ready_o;
  logic [BLOCK_W-1:0] vec_block_i;
  logic [KEY_W-1:0]   vec_key_i;
  logic [MODE_W-1:0]  vec_mode_i;
  logic               uut_rst_o;
  logic               uut_ce_o;
  logic [BLOCK_W-1:0] uut_block_o;
  logic [KEY_W-1:0]   uut_key_o;
  logic [MODE_W-1:0]  uut_mode_o;
  logic               uut_done_i;
  logic [OUT_W-1:0]   uut_result_i;
  logic               res_valid_o;
  logic               res_ready_i;
  logic [OUT_W-1:0]   res_data_o;
  logic [CNT_W-1:0]   res_cycles_o;
  logic               res_timeout_o;
  logic               busy_o;

  // controller side
  modport master (
    input  abort_i, vec_valid_i, vec_block_i, vec_key_i, vec_mode_i,
    input  uut_done_i, uut_result_i, res_ready_i,
    output vec_ready_o, uut_rst_o, uut_ce_o, uut_block_o, uut_key_o, uut_mode_o,
    output res_valid_o, res_data_o, res_cycles_o, res_timeout_o, busy_o
  );

  // harness / UUT side
  modport slave (
    output abort_i, vec_valid_i, vec_block_i, vec_key_i, vec_mode_i,
    output uut_done_i, uut_result_i, res_ready_i,
    input  vec_ready_o, uut_rst_o, uut_ce_o, uut_block_o, uut_key_o, uut_mode_o,
    input  res_valid_o, res_data_o, res_cycles_o, res_timeout_o, busy_o
  );

endinterface

// File: rtl/uut_cycle_counter.sv
// Up/down counter with clear and load; flags zero and the watchdog terminal value.
module uut_cycle_counter
  import uut_run_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  input  logic             down,
  output logic [CNT_W-1:0] count,
  output logic             zero,
  output logic             term
);

  logic [CNT_W-1:0] count_reg;

  // clear beats load beats count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en) begin
      count_reg <= down ? count_reg - 1'b1 : count_reg + 1'b1;
    end
  end

  assign count = count_reg;
  assign zero  = (count_reg == '0);
  assign term  = (count_reg == CNT_W'(TIMEOUT));

endmodule

// File: rtl/uut_run_ctrl.sv
// Run controller: accepts a vector, pulses UUT reset, runs it via clock enable,
// returns result plus latency; watchdog and abort bound every run.
module uut_run_ctrl
  import uut_run_pkg::*;
#(
  parameter int unsigned BLOCK_W    = DEF_BLOCK_W,
  parameter int unsigned KEY_W      = DEF_KEY_W,
  parameter int unsigned MODE_W     = DEF_MODE_W,
  parameter int unsigned OUT_W      = DEF_OUT_W,
  parameter int unsigned RST_CYCLES = DEF_RST_CYCLES,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input logic      clk,
  input logic      rst,
  uut_run_if.master bus
);

  state_t state_reg, state_next;

  logic             cnt_clr, cnt_load, cnt_en, cnt_down;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_zero, cnt_term;

  logic [BLOCK_W-1:0] block_reg;
  logic [KEY_W-1:0]   key_reg;
  logic [MODE_W-1:0]  mode_reg;
  logic [OUT_W-1:0]   res_data_reg;
  logic [CNT_W-1:0]   res_cycles_reg;
  logic               res_timeout_reg;

  // One counter serves both phases: RESET countdown, then RUN cycle count
  // (loaded with 1 on entry so the value always includes the current cycle).
  uut_cycle_counter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .down     (cnt_down),
    .count    (cnt_value),
    .zero     (cnt_zero),
    .term     (cnt_term)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // next state and counter control; abort overrides everything
  always_comb begin
    state_next   = state_reg;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
    cnt_down     = 1'b0;
    if (bus.abort_i) begin
      state_next = ST_IDLE;
      cnt_clr    = 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: if (bus.vec_valid_i) begin
          state_next   = ST_RESET;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(RST_CYCLES - 1);
        end
        ST_RESET: if (cnt_zero) begin
          state_next   = ST_RUN;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(1);
        end else begin
          cnt_en   = 1'b1;
          cnt_down = 1'b1;
        end
        ST_RUN: if (bus.uut_done_i || cnt_term) begin
          state_next = ST_HOLD;
        end else begin
          cnt_en = 1'b1;
        end
        ST_HOLD: if (bus.res_ready_i) state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // state-decoded outputs (driven only from the state register)
  always_comb begin
    bus.vec_ready_o = (state_reg == ST_IDLE);
    bus.uut_rst_o   = (state_reg == ST_IDLE) || (state_reg == ST_RESET);
    bus.uut_ce_o    = (state_reg == ST_RESET) || (state_reg == ST_RUN);
    bus.res_valid_o = (state_reg == ST_HOLD);
    bus.busy_o      = (state_reg != ST_IDLE);
  end

  // vector latch on acceptance; result capture on done (priority) or watchdog
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      block_reg       <= '0;
      key_reg         <= '0;
      mode_reg        <= '0;
      res_data_reg    <= '0;
      res_cycles_reg  <= '0;
      res_timeout_reg <= 1'b0;
    end else if (!bus.abort_i) begin
      if (state_reg == ST_IDLE && bus.vec_valid_i) begin
        block_reg <= bus.vec_block_i;
        key_reg   <= bus.vec_key_i;
        mode_reg  <= bus.vec_mode_i;
      end
      if (state_reg == ST_RUN) begin
        if (bus.uut_done_i) begin
          res_data_reg    <= bus.uut_result_i;
          res_cycles_reg  <= cnt_value;
          res_timeout_reg <= 1'b0;
        end else if (cnt_term) begin
          res_data_reg    <= '0;
          res_cycles_reg  <= CNT_W'(TIMEOUT);
          res_timeout_reg <= 1'b1;
        end
      end
    end
  end

  assign bus.uut_block_o   = block_reg;
  assign bus.uut_key_o     = key_reg;
  assign bus.uut_mode_o    = mode_reg;
  assign bus.res_data_o    = res_data_reg;
  assign bus.res_cycles_o  = res_cycles_reg;
  assign bus.res_timeout_o = res_timeout_reg;

endmodule
